// File: rtl/ps2_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ps2_scan_ctrl_pkg
//   Shared definitions for the PS/2 scan-code sequencer:
//   - byte constants for prefix and keyboard status bytes
//   - sequencer state encoding
//   - helper that classifies keyboard status bytes
// ---------------------------------------------------------------------------
package ps2_scan_ctrl_pkg;

   localparam logic [7:0] PS2_EXT  = 8'hE0;   // extended-key prefix
   localparam logic [7:0] PS2_BRK  = 8'hF0;   // break (release) prefix
   localparam logic [7:0] PS2_BAT  = 8'hAA;   // self-test passed
   localparam logic [7:0] PS2_ACK  = 8'hFA;   // command acknowledge
   localparam logic [7:0] PS2_RSND = 8'hFE;   // resend request
   localparam logic [7:0] PS2_ECHO = 8'hEE;   // echo response
   localparam logic [7:0] PS2_ERR0 = 8'h00;   // key detection error / overrun
   localparam logic [7:0] PS2_ERR1 = 8'hFF;   // key detection error / overrun

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_GOT_E0   = 3'd1,
      ST_GOT_F0   = 3'd2,
      ST_GOT_E0F0 = 3'd3,
      ST_RECOVER  = 3'd4
   } state_t;

   // Bytes the keyboard sends about itself rather than about a key.
   function automatic logic is_status(input logic [7:0] b);
      return (b == PS2_BAT)  || (b == PS2_ACK)  || (b == PS2_RSND) ||
             (b == PS2_ECHO) || (b == PS2_ERR0) || (b == PS2_ERR1);
   endfunction

endpackage

// File: rtl/ps2_scan_ctrl_watchdog.sv
// ---------------------------------------------------------------------------
// ps2_watchdog
//   Frame/sequence watchdog counter.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   run_i    : count enable (counter is held at 0 when low)
//   clr_i    : restart the count (a byte just arrived)
//   expire_o : one-cycle pulse when the count reaches TIMEOUT_CYC-1
// ---------------------------------------------------------------------------
module ps2_watchdog #(
   parameter int TIMEOUT_CYC = 100000,
   parameter int CNT_W       = 17
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic run_i,
   input  logic clr_i,
   output logic expire_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             expire;

   always_comb begin
      expire = run_i && !clr_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
      cnt_d  = cnt_q + 1'b1;
      // Expiry restarts the count so the pulse is a single cycle.
      if (clr_i || !run_i || expire) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = expire;

endmodule

// File: rtl/ps2_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_scan_ctrl
//   Sequencer between a PS/2 byte receiver and downstream key-command logic.
//   Folds E0/F0 prefixes into single key events, drops keyboard status
//   bytes, recovers a stalled receiver via a watchdog, and presents events
//   through a one-deep valid/ready slot.
//   Receiver side : rx_done_i, rx_data_i, rx_busy_i in; rx_en_o, rx_rst_o out
//   Event side    : evt_valid_o, evt_code_o, evt_release_o, evt_ext_o out;
//                   evt_ready_i in
//   Status        : clr_i in; overflow_o, err_proto_o, err_timeout_o sticky
// ---------------------------------------------------------------------------
import ps2_scan_ctrl_pkg::*;

module ps2_scan_ctrl #(
   parameter int TIMEOUT_CYC = 100000,
   parameter int CNT_W       = 17,
   parameter int RECOVER_CYC = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_done_i,
   input  logic [7:0] rx_data_i,
   input  logic       rx_busy_i,
   output logic       rx_en_o,
   output logic       rx_rst_o,
   output logic       evt_valid_o,
   input  logic       evt_ready_i,
   output logic [7:0] evt_code_o,
   output logic       evt_release_o,
   output logic       evt_ext_o,
   input  logic       clr_i,
   output logic       overflow_o,
   output logic       err_proto_o,
   output logic       err_timeout_o
);

   state_t     state_q,     state_d;
   logic [7:0] rec_cnt_q,   rec_cnt_d;
   logic       rx_en_q,     rx_en_d;
   logic       rx_rst_q,    rx_rst_d;
   logic       evt_valid_q, evt_valid_d;
   logic [7:0] evt_code_q,  evt_code_d;
   logic       evt_rel_q,   evt_rel_d;
   logic       evt_ext_q,   evt_ext_d;
   logic       ovf_q,       ovf_d;
   logic       proto_q,     proto_d;
   logic       tout_q,      tout_d;

   logic       emit;
   logic       emit_rel;
   logic       emit_ext;
   logic       proto_set;
   logic       wd_run;
   logic       wd_expire;

   // Watchdog runs while a prefix is pending or a frame is in flight.
   assign wd_run = (state_q != ST_RECOVER) && ((state_q != ST_IDLE) || rx_busy_i);

   ps2_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .CNT_W       (CNT_W)
   ) u_watchdog (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .run_i    (wd_run),
      .clr_i    (rx_done_i),
      .expire_o (wd_expire)
   );

   // Next-state / event decode
   always_comb begin
      state_d   = state_q;
      rec_cnt_d = rec_cnt_q;
      emit      = 1'b0;
      emit_rel  = 1'b0;
      emit_ext  = 1'b0;
      proto_set = 1'b0;

      if (state_q == ST_RECOVER) begin
         if (rec_cnt_q == 8'(RECOVER_CYC - 1)) begin
            state_d   = ST_IDLE;
            rec_cnt_d = '0;
         end else begin
            rec_cnt_d = rec_cnt_q + 8'd1;
         end
      end else if (wd_expire) begin
         state_d   = ST_RECOVER;
         rec_cnt_d = '0;
      end else if (rx_done_i) begin
         unique case (state_q)
            ST_IDLE: begin
               if (rx_data_i == PS2_EXT) begin
                  state_d = ST_GOT_E0;
               end else if (rx_data_i == PS2_BRK) begin
                  state_d = ST_GOT_F0;
               end else if (!is_status(rx_data_i)) begin
                  emit = 1'b1;
               end
            end
            ST_GOT_E0: begin
               if (rx_data_i == PS2_BRK) begin
                  state_d = ST_GOT_E0F0;
               end else if (rx_data_i != PS2_EXT) begin
                  emit     = 1'b1;
                  emit_ext = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
            ST_GOT_F0, ST_GOT_E0F0: begin
               state_d = ST_IDLE;
               if ((rx_data_i == PS2_EXT) || (rx_data_i == PS2_BRK)) begin
                  proto_set = 1'b1;
               end else begin
                  emit     = 1'b1;
                  emit_rel = 1'b1;
                  emit_ext = (state_q == ST_GOT_E0F0);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Event slot, sticky flags and registered receiver controls
   always_comb begin
      evt_valid_d = evt_valid_q;
      evt_code_d  = evt_code_q;
      evt_rel_d   = evt_rel_q;
      evt_ext_d   = evt_ext_q;
      rx_en_d     = (state_d != ST_RECOVER);
      rx_rst_d    = (state_d == ST_RECOVER);

      // Slot is writable if empty or being drained this very cycle.
      if (emit && (!evt_valid_q || evt_ready_i)) begin
         evt_valid_d = 1'b1;
         evt_code_d  = rx_data_i;
         evt_rel_d   = emit_rel;
         evt_ext_d   = emit_ext;
      end else if (evt_valid_q && evt_ready_i) begin
         evt_valid_d = 1'b0;
      end

      // A set wins over a simultaneous clear.
      ovf_d   = (emit && evt_valid_q && !evt_ready_i) || (ovf_q && !clr_i);
      proto_d = proto_set || (proto_q && !clr_i);
      tout_d  = (wd_expire && (state_q != ST_RECOVER)) || (tout_q && !clr_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         rec_cnt_q   <= '0;
         rx_en_q     <= 1'b0;
         rx_rst_q    <= 1'b0;
         evt_valid_q <= 1'b0;
         evt_code_q  <= '0;
         evt_rel_q   <= 1'b0;
         evt_ext_q   <= 1'b0;
         ovf_q       <= 1'b0;
         proto_q     <= 1'b0;
         tout_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rec_cnt_q   <= rec_cnt_d;
         rx_en_q     <= rx_en_d;
         rx_rst_q    <= rx_rst_d;
         evt_valid_q <= evt_valid_d;
         evt_code_q  <= evt_code_d;
         evt_rel_q   <= evt_rel_d;
         evt_ext_q   <= evt_ext_d;
         ovf_q       <= ovf_d;
         proto_q     <= proto_d;
         tout_q      <= tout_d;
      end
   end

   assign rx_en_o       = rx_en_q;
   assign rx_rst_o      = rx_rst_q;
   assign evt_valid_o   = evt_valid_q;
   assign evt_code_o    = evt_code_q;
   assign evt_release_o = evt_rel_q;
   assign evt_ext_o     = evt_ext_q;
   assign overflow_o    = ovf_q;
   assign err_proto_o   = proto_q;
   assign err_timeout_o = tout_q;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ps2_scan_ctrl
//   Directed bench for ps2_scan_ctrl: a table of single-byte vectors with
//   hand-computed events, followed by hand-written sequences for overflow,
//   protocol errors, reset mid-sequence and watchdog recovery.
// ---------------------------------------------------------------------------
module tb_ps2_scan_ctrl;

   localparam int T_CYC = 20;   // shortened watchdog for simulation
   localparam int T_W   = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_done;
   logic [7:0] rx_data;
   logic       rx_busy;
   logic       rx_en;
   logic       rx_rst;
   logic       evt_valid;
   logic       evt_ready;
   logic [7:0] evt_code;
   logic       evt_release;
   logic       evt_ext;
   logic       clr;
   logic       overflow;
   logic       err_proto;
   logic       err_timeout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ps2_scan_ctrl #(
      .TIMEOUT_CYC (T_CYC),
      .CNT_W       (T_W),
      .RECOVER_CYC (4)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .rx_done_i     (rx_done),
      .rx_data_i     (rx_data),
      .rx_busy_i     (rx_busy),
      .rx_en_o       (rx_en),
      .rx_rst_o      (rx_rst),
      .evt_valid_o   (evt_valid),
      .evt_ready_i   (evt_ready),
      .evt_code_o    (evt_code),
      .evt_release_o (evt_release),
      .evt_ext_o     (evt_ext),
      .clr_i         (clr),
      .overflow_o    (overflow),
      .err_proto_o   (err_proto),
      .err_timeout_o (err_timeout)
   );

   typedef struct {
      logic [7:0] data;
      logic       exp_valid;
      logic [7:0] exp_code;
      logic       exp_rel;
      logic       exp_ext;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one rx_done pulse at a falling edge; return at the next falling
   // edge, i.e. just after the rising edge that consumed the byte.
   task automatic send_byte(input logic [7:0] b, input logic rdy);
      @(negedge clk);
      rx_done   = 1'b1;
      rx_data   = b;
      evt_ready = rdy;
      @(negedge clk);
      rx_done   = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench did not finish");
   end

   initial begin
      int cycles;
      int n;
      int bad;

      vecs[0]  = '{8'h31, 1'b1, 8'h31, 1'b0, 1'b0};   // plain make
      vecs[1]  = '{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0};   // break prefix
      vecs[2]  = '{8'h31, 1'b1, 8'h31, 1'b1, 1'b0};   // break of 31
      vecs[3]  = '{8'hE0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[4]  = '{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[5]  = '{8'h75, 1'b1, 8'h75, 1'b1, 1'b1};   // extended break
      vecs[6]  = '{8'hAA, 1'b0, 8'h00, 1'b0, 1'b0};   // status byte dropped
      vecs[7]  = '{8'hE0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[8]  = '{8'hE0, 1'b0, 8'h00, 1'b0, 1'b0};   // repeated E0 keeps prefix
      vecs[9]  = '{8'h6B, 1'b1, 8'h6B, 1'b0, 1'b1};   // extended make
      vecs[10] = '{8'hFA, 1'b0, 8'h00, 1'b0, 1'b0};   // ACK dropped
      vecs[11] = '{8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0};

      rst       = 1'b1;
      rx_done   = 1'b0;
      rx_data   = 8'h00;
      rx_busy   = 1'b0;
      evt_ready = 1'b0;
      clr       = 1'b0;

      // ---- reset state
      repeat (3) @(negedge clk);
      chk("rst_rx_en",    32'(rx_en), 0);
      chk("rst_rx_rst",   32'(rx_rst), 0);
      chk("rst_valid",    32'(evt_valid), 0);
      chk("rst_flags",    {29'd0, overflow, err_proto, err_timeout}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rx_en_after_rst", 32'(rx_en), 1);

      // ---- table-driven single bytes, downstream always ready
      for (int i = 0; i < 12; i++) begin
         send_byte(vecs[i].data, 1'b1);
         $display("vec %0d byte %02h -> valid %0b code %02h rel %0b ext %0b",
                  i, vecs[i].data, evt_valid, evt_code, evt_release, evt_ext);
         chk($sformatf("vec%0d_valid", i), 32'(evt_valid), 32'(vecs[i].exp_valid));
         if (vecs[i].exp_valid) begin
            chk($sformatf("vec%0d_code", i), 32'(evt_code), 32'(vecs[i].exp_code));
            chk($sformatf("vec%0d_rel", i),  32'(evt_release), 32'(vecs[i].exp_rel));
            chk($sformatf("vec%0d_ext", i),  32'(evt_ext), 32'(vecs[i].exp_ext));
         end
         chk($sformatf("vec%0d_flags", i), {30'd0, overflow, err_proto}, 0);
         @(negedge clk);
         chk($sformatf("vec%0d_drain", i), 32'(evt_valid), 0);
      end

      // ---- overflow: slot full, second event dropped
      send_byte(8'h31, 1'b0);
      $display("ovf step1 valid %0b code %02h ovf %0b", evt_valid, evt_code, overflow);
      chk("ovf_first_valid", 32'(evt_valid), 1);
      chk("ovf_first_ovf",   32'(overflow), 0);
      send_byte(8'h32, 1'b0);
      $display("ovf step2 valid %0b code %02h ovf %0b", evt_valid, evt_code, overflow);
      chk("ovf_hold_code", 32'(evt_code), 32'h31);
      chk("ovf_set",       32'(overflow), 1);
      evt_ready = 1'b1;
      @(negedge clk);
      chk("ovf_accept_valid", 32'(evt_valid), 0);
      chk("ovf_sticky",       32'(overflow), 1);
      evt_ready = 1'b0;
      pulse_clr();
      chk("ovf_clr", 32'(overflow), 0);
      // refill on the cycle the slot drains
      send_byte(8'h41, 1'b0);
      chk("refill_first_code", 32'(evt_code), 32'h41);
      send_byte(8'h42, 1'b1);
      $display("refill valid %0b code %02h ovf %0b", evt_valid, evt_code, overflow);
      chk("refill_valid", 32'(evt_valid), 1);
      chk("refill_code",  32'(evt_code), 32'h42);
      chk("refill_ovf",   32'(overflow), 0);
      @(negedge clk);
      chk("refill_drain", 32'(evt_valid), 0);

      // ---- protocol error F0 F0
      send_byte(8'hF0, 1'b1);
      send_byte(8'hF0, 1'b1);
      $display("proto valid %0b err_proto %0b", evt_valid, err_proto);
      chk("proto_set",   32'(err_proto), 1);
      chk("proto_noevt", 32'(evt_valid), 0);
      pulse_clr();
      chk("proto_clr", 32'(err_proto), 0);
      // set and clear in the same cycle: set wins
      send_byte(8'hF0, 1'b1);
      @(negedge clk);
      rx_done = 1'b1;
      rx_data = 8'hF0;
      clr     = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      clr     = 1'b0;
      chk("proto_set_over_clr", 32'(err_proto), 1);
      pulse_clr();
      send_byte(8'h31, 1'b1);
      chk("after_proto_evt", {23'd0, evt_valid, evt_code, evt_release, evt_ext}, {23'd0, 1'b1, 8'h31, 1'b0, 1'b0});
      @(negedge clk);

      // ---- reset mid-sequence with a full slot
      send_byte(8'h55, 1'b0);
      send_byte(8'hE0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_valid", 32'(evt_valid), 0);
      @(negedge clk);
      send_byte(8'h31, 1'b1);
      $display("after rst valid %0b code %02h ext %0b", evt_valid, evt_code, evt_ext);
      chk("rst_mid_evt", {23'd0, evt_valid, evt_code, evt_release, evt_ext}, {23'd0, 1'b1, 8'h31, 1'b0, 1'b0});
      @(negedge clk);

      // ---- watchdog on pending E0 prefix
      send_byte(8'hE0, 1'b1);
      cycles = 0;
      while (!rx_rst && cycles < T_CYC + 10) begin
         @(negedge clk);
         cycles++;
      end
      $display("timeout after %0d cycles rx_rst %0b err_timeout %0b", cycles, rx_rst, err_timeout);
      chk("tmo_latency_ok", 32'((cycles >= T_CYC - 1) && (cycles <= T_CYC + 1)), 1);
      chk("tmo_flag", 32'(err_timeout), 1);
      n   = 0;
      bad = 0;
      while (rx_rst && n < 20) begin
         if (rx_en) bad++;
         n++;
         @(negedge clk);
      end
      chk("recover_len",   32'(n), 4);
      chk("recover_rx_en", 32'(bad), 0);
      chk("recover_exit_en", 32'(rx_en), 1);
      send_byte(8'h31, 1'b1);
      $display("after recover valid %0b code %02h ext %0b", evt_valid, evt_code, evt_ext);
      chk("recover_evt", {23'd0, evt_valid, evt_code, evt_release, evt_ext}, {23'd0, 1'b1, 8'h31, 1'b0, 1'b0});
      @(negedge clk);

      // ---- watchdog on a stuck frame; a byte during RECOVER is ignored
      pulse_clr();
      chk("tmo_clr", 32'(err_timeout), 0);
      rx_busy = 1'b1;
      cycles  = 0;
      while (!rx_rst && cycles < T_CYC + 10) begin
         @(negedge clk);
         cycles++;
      end
      $display("busy timeout after %0d cycles rx_rst %0b", cycles, rx_rst);
      chk("busy_tmo_ok", 32'((cycles >= T_CYC - 1) && (cycles <= T_CYC + 2)), 1);
      chk("busy_tmo_flag", 32'(err_timeout), 1);
      rx_busy = 1'b0;
      rx_done = 1'b1;
      rx_data = 8'h31;
      @(negedge clk);
      rx_done = 1'b0;
      n = 0;
      while (rx_rst && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("recover_ignores_byte", 32'(evt_valid), 0);
      chk("busy_recover_exit", 32'(rx_rst), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
